hexaram_arbiter: RTL and testbench

Port scheduler for the 6-read/2-write hexaram register file (three replicated dual-port RAMs). It shares the two write ports among four write requesters with round-robin fairness and maps six read requesters onto read ports a–f. It blocks reads whose replica port is hijacked by an active write, and bounds read starvation. It sits between the execution units and the hexaram; all RAM-side outputs are registered.

---
 rtl/hexaram_arbiter_if.sv | 34 +++
 rtl/hexaram_arbiter.sv | 152 +++++++++++++++
 tb/tb_hexaram_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hexaram_arbiter_if.sv
// Request/grant and RAM-side bundle for the hexaram port scheduler.
// Arrays are indexed by requester (writes 0..3) and by read port (a..f = 0..5).
interface hexaram_arbiter_if #(parameter int W = 16) ();
   logic [3:0]          wr_req;
   logic [3:0][W-1:0]   wr_addr;
   logic [3:0][W-1:0]   wr_data;
   logic [3:0]          wr_gnt;
   logic [5:0]          rd_req;
   logic [5:0][W-1:0]   rd_addr;
   logic [5:0]          rd_gnt;
   logic [5:0]          rd_valid;
   logic                we_a;
   logic                we_b;
   logic [W-1:0]        data_a;
   logic [W-1:0]        data_b;
   logic [W-1:0]        addr_a;
   logic [W-1:0]        addr_b;
   logic [W-1:0]        addr_c;
   logic [W-1:0]        addr_d;
   logic [W-1:0]        addr_e;
   logic [W-1:0]        addr_f;

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr,
      input  wr_gnt, rd_gnt, rd_valid, we_a, we_b, data_a, data_b,
      input  addr_a, addr_b, addr_c, addr_d, addr_e, addr_f
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
      output wr_gnt, rd_gnt, rd_valid, we_a, we_b, data_a, data_b,
      output addr_a, addr_b, addr_c, addr_d, addr_e, addr_f
   );
endinterface

// File: rtl/hexaram_arbiter.sv
// Port scheduler for the 6R/2W hexaram: round-robin write sharing over
// ports A/B, group read blocking and bounded read starvation.
module hexaram_arbiter #(
   parameter int W         = 16,
   parameter int RD_STARVE = 3
) (
   input logic               clk,
   input logic               rst_n,
   hexaram_arbiter_if.slave  bus
);
   localparam int CW = (RD_STARVE < 1) ? 1 : $clog2(RD_STARVE + 1);
   localparam logic [CW-1:0] CMAX = CW'(RD_STARVE);
   localparam logic [5:0] GRP_A = 6'b010101;
   localparam logic [5:0] GRP_B = 6'b101010;

   logic [1:0]          r_ptr;
   logic [CW-1:0]       r_cnt_a;
   logic [CW-1:0]       r_cnt_b;
   logic                r_we_a;
   logic                r_we_b;
   logic [W-1:0]        r_data_a;
   logic [W-1:0]        r_data_b;
   logic [5:0][W-1:0]   r_addr;
   logic [5:0]          r_rd_q;
   logic [5:0]          r_rd_valid;

   logic                w_res_a;
   logic                w_res_b;
   logic [1:0]          w_idx;
   logic [1:0]          w_f1;
   logic [1:0]          w_f2;
   logic                w_f1_ok;
   logic                w_f2_ok;
   logic                w_same;
   logic                w_gnt_a;
   logic                w_gnt_b;
   logic [1:0]          w_sel_a;
   logic [1:0]          w_sel_b;
   logic [1:0]          w_last;
   logic [3:0]          w_wr_gnt;
   logic [5:0]          w_rd_gnt;
   logic                w_pend_a;
   logic                w_pend_b;
   logic [1:0][W-1:0]   w_waddr;

   always_comb begin
      w_res_a  = (r_cnt_a == CMAX);
      w_res_b  = (r_cnt_b == CMAX);
      w_idx    = '0;
      w_f1     = '0;
      w_f2     = '0;
      w_f1_ok  = 1'b0;
      w_f2_ok  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (bus.wr_req[w_idx]) begin
            if (!w_f1_ok) begin
               w_f1_ok = 1'b1;
               w_f1    = w_idx;
            end else if (!w_f2_ok) begin
               w_f2_ok = 1'b1;
               w_f2    = w_idx;
            end
         end
      end
      w_same  = (bus.wr_addr[w_f1] == bus.wr_addr[w_f2]);
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      w_sel_a = w_f1;
      w_sel_b = w_f2;
      unique case (1'b1)
         (w_res_a && w_res_b): ;
         (w_res_a && !w_res_b): begin
            w_gnt_b = w_f1_ok;
            w_sel_b = w_f1;
         end
         (!w_res_a && w_res_b): begin
            w_gnt_a = w_f1_ok;
            w_sel_a = w_f1;
         end
         default: begin
            w_gnt_a = w_f1_ok;
            w_gnt_b = w_f2_ok && !w_same;
         end
      endcase
      w_wr_gnt = '0;
      if (w_gnt_a) w_wr_gnt[w_sel_a] = 1'b1;
      if (w_gnt_b) w_wr_gnt[w_sel_b] = 1'b1;
      // only a double grant can end on the second scan winner
      w_last   = (w_gnt_a && w_gnt_b) ? w_f2 : w_f1;
      w_rd_gnt = bus.rd_req & ~{3{w_gnt_b, w_gnt_a}};
      w_pend_a = |(bus.rd_req & GRP_A);
      w_pend_b = |(bus.rd_req & GRP_B);
      w_waddr[0] = bus.wr_addr[w_sel_a];
      w_waddr[1] = bus.wr_addr[w_sel_b];
   end

   assign bus.wr_gnt = w_wr_gnt;
   assign bus.rd_gnt = w_rd_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_cnt_a    <= '0;
         r_cnt_b    <= '0;
         r_we_a     <= 1'b0;
         r_we_b     <= 1'b0;
         r_data_a   <= '0;
         r_data_b   <= '0;
         r_addr     <= '0;
         r_rd_q     <= '0;
         r_rd_valid <= '0;
      end else begin
         r_we_a     <= w_gnt_a;
         r_we_b     <= w_gnt_b;
         r_rd_q     <= w_rd_gnt;
         r_rd_valid <= r_rd_q;
         if (w_gnt_a || w_gnt_b) r_ptr <= w_last + 2'd1;
         if (w_gnt_a) r_data_a <= bus.wr_data[w_sel_a];
         if (w_gnt_b) r_data_b <= bus.wr_data[w_sel_b];
         // a write drives its address onto every replica of its group
         for (int i = 0; i < 6; i++) begin
            if ((i % 2 == 0) ? w_gnt_a : w_gnt_b)
               r_addr[i] <= w_waddr[i % 2];
            else if (w_rd_gnt[i])
               r_addr[i] <= bus.rd_addr[i];
         end
         if (w_pend_a && w_gnt_a) begin
            if (r_cnt_a != CMAX) r_cnt_a <= r_cnt_a + 1'b1;
         end else if (w_pend_a) begin
            r_cnt_a <= '0;
         end
         if (w_pend_b && w_gnt_b) begin
            if (r_cnt_b != CMAX) r_cnt_b <= r_cnt_b + 1'b1;
         end else if (w_pend_b) begin
            r_cnt_b <= '0;
         end
      end
   end

   assign bus.we_a     = r_we_a;
   assign bus.we_b     = r_we_b;
   assign bus.data_a   = r_data_a;
   assign bus.data_b   = r_data_b;
   assign bus.addr_a   = r_addr[0];
   assign bus.addr_b   = r_addr[1];
   assign bus.addr_c   = r_addr[2];
   assign bus.addr_d   = r_addr[3];
   assign bus.addr_e   = r_addr[4];
   assign bus.addr_f   = r_addr[5];
   assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_hexaram_arbiter.sv
// Bench for hexaram_arbiter: directed grant checks plus a read-data
// scoreboard against a small behavioural hexaram.
module tb_hexaram_arbiter;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hexaram_arbiter_if #(.W(W)) bus ();

   hexaram_arbiter #(.W(W), .RD_STARVE(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // behavioural RAM: reads sample old data before same-edge writes
   logic [W-1:0] mem [256] = '{default: '0};
   logic [5:0][W-1:0] q;

   always @(posedge clk) begin
      q[0] <= mem[bus.addr_a[7:0]];
      q[1] <= mem[bus.addr_b[7:0]];
      q[2] <= mem[bus.addr_c[7:0]];
      q[3] <= mem[bus.addr_d[7:0]];
      q[4] <= mem[bus.addr_e[7:0]];
      q[5] <= mem[bus.addr_f[7:0]];
      if (bus.we_a) mem[bus.addr_a[7:0]] <= bus.data_a;
      if (bus.we_b) mem[bus.addr_b[7:0]] <= bus.data_b;
   end

   typedef struct {
      int           port;
      logic [W-1:0] data;
      int           due;
   } rd_exp_t;

   rd_exp_t sbq[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rd(input int port, input logic [W-1:0] data);
      rd_exp_t e;
      e.port = port;
      e.data = data;
      e.due  = cyc + 2;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (bus.rd_valid != 6'b0 && sbq.size() == 0) begin
         chk("rd_spurious", {26'b0, bus.rd_valid}, 32'd0);
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (bus.rd_valid[i] && sbq.size() != 0) begin
               rd_exp_t e;
               e = sbq.pop_front();
               chk("rd_port", i, e.port);
               chk("rd_lat", cyc, e.due);
               chk("rd_data", {16'b0, q[i]}, {16'b0, e.data});
            end
         end
      end
   end

   initial begin
      int gcount [4];
      for (int i = 0; i < 4; i++) begin
         gcount[i] = 0;
         bus.wr_addr[i] = W'(16 + i);
         bus.wr_data[i] = W'(16'h100 + i);
      end
      for (int i = 0; i < 6; i++) bus.rd_addr[i] = '0;
      bus.wr_req = 4'b1111;
      bus.rd_req = 6'b0;

      // reset defaults and first arbitration
      tick();
      tick();
      @(negedge clk);
      chk("rst_we_a", bus.we_a, 1'b0);
      chk("rst_we_b", bus.we_b, 1'b0);
      chk("rst_rdv", bus.rd_valid, 6'b0);
      chk("rst_addr_a", bus.addr_a, 16'h0);
      chk("rst_gnt", bus.wr_gnt, 4'b0011);
      rst_n = 1'b1;
      #1;
      chk("first_gnt", bus.wr_gnt, 4'b0011);
      tick();
      @(negedge clk);
      chk("second_gnt", bus.wr_gnt, 4'b1100);
      chk("first_we_a", bus.we_a, 1'b1);
      chk("first_we_b", bus.we_b, 1'b1);
      chk("first_addr_a", bus.addr_a, 16'd16);
      chk("first_addr_b", bus.addr_b, 16'd17);
      chk("first_data_a", bus.data_a, 16'h100);
      tick();

      // round robin over four cycles
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rr_gnt", bus.wr_gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
         if (c == 0) begin
            chk("rr_addr_c", bus.addr_c, 16'd18);
            chk("rr_addr_e", bus.addr_e, 16'd18);
            chk("rr_addr_d", bus.addr_d, 16'd19);
         end
         for (int j = 0; j < 4; j++) gcount[j] += int'(bus.wr_gnt[j]);
         tick();
      end
      for (int j = 0; j < 4; j++) chk("rr_fair", gcount[j], 2);

      // same-address conflict, then read-back on port b
      bus.wr_req = 4'b0011;
      bus.wr_addr[0] = 16'd5;
      bus.wr_addr[1] = 16'd5;
      bus.wr_data[0] = 16'hA;
      bus.wr_data[1] = 16'hB;
      @(negedge clk);
      chk("same_gnt1", bus.wr_gnt, 4'b0001);
      tick();
      bus.wr_req = 4'b0010;
      @(negedge clk);
      chk("same_gnt2", bus.wr_gnt, 4'b0010);
      chk("same_we_a", bus.we_a, 1'b1);
      chk("same_we_b", bus.we_b, 1'b0);
      chk("same_data_a", bus.data_a, 16'hA);
      tick();
      bus.wr_req = 4'b0;
      bus.rd_req = 6'b000010;
      bus.rd_addr[1] = 16'd5;
      @(negedge clk);
      chk("same_rd_gnt", bus.rd_gnt, 6'b000010);
      chk("same_data_b", bus.data_a, 16'hB);
      push_rd(1, 16'hB);
      tick();
      bus.rd_req = 6'b0;

      // group blocking: write on A holds off read on c
      bus.wr_req = 4'b0100;
      bus.wr_addr[2] = 16'd3;
      bus.wr_data[2] = 16'h55;
      bus.rd_req = 6'b000100;
      bus.rd_addr[2] = 16'd3;
      @(negedge clk);
      chk("blk_wr_gnt", bus.wr_gnt, 4'b0100);
      chk("blk_rd_gnt", bus.rd_gnt, 6'b0);
      tick();
      bus.wr_req = 4'b0;
      @(negedge clk);
      chk("blk_rd_gnt2", bus.rd_gnt, 6'b000100);
      push_rd(2, 16'h55);
      tick();
      bus.rd_req = 6'b0;

      // starvation: reserved group A pushes the write to port B
      bus.wr_req = 4'b0001;
      bus.wr_addr[0] = 16'd40;
      bus.wr_data[0] = 16'h77;
      bus.rd_req = 6'b000001;
      bus.rd_addr[0] = 16'd16;
      for (int s = 1; s <= 3; s++) begin
         @(negedge clk);
         chk("stv_wr_gnt", bus.wr_gnt, 4'b0001);
         chk("stv_rd_blk", bus.rd_gnt, 6'b0);
         if (s > 1) chk("stv_we_a", bus.we_a, 1'b1);
         tick();
      end
      @(negedge clk);
      chk("stv_rd_gnt", bus.rd_gnt, 6'b000001);
      chk("stv_wr_gnt4", bus.wr_gnt, 4'b0001);
      push_rd(0, 16'h100);
      tick();
      bus.wr_req = 4'b0;
      bus.rd_req = 6'b0;
      @(negedge clk);
      chk("stv_we_b", bus.we_b, 1'b1);
      chk("stv_we_a0", bus.we_a, 1'b0);
      chk("stv_addr_b", bus.addr_b, 16'd40);
      tick();

      // reset in the cycle after a write grant aborts write and read
      bus.wr_req = 4'b0001;
      bus.wr_addr[0] = 16'd50;
      bus.wr_data[0] = 16'h99;
      bus.rd_req = 6'b000010;
      bus.rd_addr[1] = 16'd16;
      @(negedge clk);
      chk("mid_wr_gnt", bus.wr_gnt, 4'b0001);
      chk("mid_rd_gnt", bus.rd_gnt, 6'b000010);
      tick();
      rst_n = 1'b0;
      bus.wr_req = 4'b0;
      bus.rd_req = 6'b0;
      @(negedge clk);
      chk("mid_we_a", bus.we_a, 1'b0);
      chk("mid_rdv", bus.rd_valid, 6'b0);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      bus.rd_req = 6'b000001;
      bus.rd_addr[0] = 16'd50;
      @(negedge clk);
      chk("mid_rd_gnt2", bus.rd_gnt, 6'b000001);
      push_rd(0, 16'h0);
      tick();
      bus.rd_req = 6'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("sb_empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
